// File: rtl/reg_file_if.sv
// Register file access bundle: ID read requests and write-back updates
// on one side, the register file responder on the other.
interface reg_file_if #(
    parameter int REG_LENGTH   = 32,
    parameter int REG_ADDR_LEN = 5
);
    logic                    regcWr;
    logic [REG_ADDR_LEN-1:0] regcAddr;
    logic [REG_LENGTH-1:0]   regcData;
    logic                    regaRd;
    logic [REG_ADDR_LEN-1:0] regaAddr;
    logic [REG_LENGTH-1:0]   regaData;
    logic                    regbRd;
    logic [REG_ADDR_LEN-1:0] regbAddr;
    logic [REG_LENGTH-1:0]   regbData;

    modport master (
        output regcWr, regcAddr, regcData,
        output regaRd, regaAddr,
        output regbRd, regbAddr,
        input  regaData, regbData
    );

    modport slave (
        input  regcWr, regcAddr, regcData,
        input  regaRd, regaAddr,
        input  regbRd, regbAddr,
        output regaData, regbData
    );
endinterface

// File: rtl/reg_file.sv
// MIPS general-purpose register file: two combinational read ports with
// same-cycle write bypass, one synchronous write port, $0 tied to zero.
module reg_file #(
    parameter int REG_LENGTH   = 32,
    parameter int REG_ADDR_LEN = 5,
    parameter int REG_NUM      = 32
) (
    input  logic       clk,
    input  logic       rst,
    reg_file_if.slave  rf_bus
);
    logic [REG_LENGTH-1:0] r_regs [REG_NUM];

    logic w_wr_en;
    logic w_hit_a;
    logic w_hit_b;

    assign w_wr_en = rf_bus.regcWr && (rf_bus.regcAddr != '0);
    assign w_hit_a = rf_bus.regcWr && (rf_bus.regcAddr == rf_bus.regaAddr);
    assign w_hit_b = rf_bus.regcWr && (rf_bus.regcAddr == rf_bus.regbAddr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[rf_bus.regcAddr] <= rf_bus.regcData;
        end
    end

    // Write-first bypass lets ID see a value in the cycle it is written back.
    always_comb begin
        rf_bus.regaData = '0;
        if (rst || !rf_bus.regaRd || rf_bus.regaAddr == '0) begin
            rf_bus.regaData = '0;
        end else if (w_hit_a) begin
            rf_bus.regaData = rf_bus.regcData;
        end else begin
            rf_bus.regaData = r_regs[rf_bus.regaAddr];
        end
    end

    always_comb begin
        rf_bus.regbData = '0;
        if (rst || !rf_bus.regbRd || rf_bus.regbAddr == '0) begin
            rf_bus.regbData = '0;
        end else if (w_hit_b) begin
            rf_bus.regbData = rf_bus.regcData;
        end else begin
            rf_bus.regbData = r_regs[rf_bus.regbAddr];
        end
    end
endmodule
